// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: forwarding select codes,
// result-source encoding and shadow-slot widths.
package hazard_pkg;

  // Forwarding mux select. The mux input order is RF, WB, MEM.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Flag bits in a slot: reg_write and is_load.
  localparam int unsigned SLOT_FLAG_W = 2;

  // EX slot: {rd, reg_write, is_load, rs1, rs2}.
  function automatic int unsigned ex_slot_width(input int unsigned addr_w);
    return 3 * addr_w + SLOT_FLAG_W;
  endfunction

  // MEM/WB slots: {rd, reg_write}.
  function automatic int unsigned prod_slot_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline slot: a register with synchronous reset and
// flush-to-bubble (a bubble is all zero).
module hazard_shadow_stage #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] slot_q;
  logic [WIDTH-1:0] slot_d;

  // Next slot value: a bubble on flush, otherwise the upstream fields.
  always_comb begin
    slot_d = d_i;
    if (flush_i) slot_d = '0;
  end

  // Slot register; reset wipes it to a bubble.
  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign q_o = slot_q;

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for a 5-stage pipeline: EX operand-forwarding selects,
// load-use stall and branch flush control, driven from its own shadow
// copy of the EX/MEM/WB destination fields.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush
// cycle counters (ports stall_cycles / flush_cycles).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_result_src,
  input  logic                  ex_pc_src,
  output logic [1:0]            forward_a_e,
  output logic [1:0]            forward_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  flush_e
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_cycles
`endif
);

  localparam int unsigned EX_W   = ex_slot_width(REG_ADDR_W);
  localparam int unsigned PROD_W = prod_slot_width(REG_ADDR_W);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } ex_slot_t;

  // MEM and WB slots keep only what forwarding compares against; the
  // load flag and source fields are never consulted past EX.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } prod_slot_t;

  ex_slot_t   id_slot;
  ex_slot_t   e_q;
  prod_slot_t e_prod;
  prod_slot_t m_q;
  prod_slot_t w_q;

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     lw_stall;

  // Decode-stage fields packed into an EX slot.
  always_comb begin
    id_slot.rd        = id_rd;
    id_slot.reg_write = id_reg_write;
    id_slot.is_load   = (id_result_src == RESULT_SRC_LOAD);
    id_slot.rs1       = id_rs1;
    id_slot.rs2       = id_rs2;
  end

  assign e_prod = '{rd: e_q.rd, reg_write: e_q.reg_write};

  hazard_shadow_stage #(.WIDTH(EX_W)) u_stage_e (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_e),
    .d_i     (id_slot),
    .q_o     (e_q)
  );

  hazard_shadow_stage #(.WIDTH(PROD_W)) u_stage_m (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .d_i     (e_prod),
    .q_o     (m_q)
  );

  hazard_shadow_stage #(.WIDTH(PROD_W)) u_stage_w (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .d_i     (m_q),
    .q_o     (w_q)
  );

  // Forwarding selects (MEM beats WB, x0 never forwarded), load-use
  // detection, and stall/flush; everything forced low during reset.
  always_comb begin
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    lw_stall = 1'b0;

    if (m_q.reg_write && m_q.rd != '0 && m_q.rd == e_q.rs1)      fwd_a = FWD_MEM;
    else if (w_q.reg_write && w_q.rd != '0 && w_q.rd == e_q.rs1) fwd_a = FWD_WB;

    if (m_q.reg_write && m_q.rd != '0 && m_q.rd == e_q.rs2)      fwd_b = FWD_MEM;
    else if (w_q.reg_write && w_q.rd != '0 && w_q.rd == e_q.rs2) fwd_b = FWD_WB;

    lw_stall = e_q.is_load && (e_q.rd != '0) &&
               ((e_q.rd == id_rs1) || (e_q.rd == id_rs2));

    forward_a_e = fwd_a;
    forward_b_e = fwd_b;
    stall_f     = lw_stall && !ex_pc_src;
    stall_d     = lw_stall && !ex_pc_src;
    flush_d     = ex_pc_src;
    flush_e     = lw_stall || ex_pc_src;

    if (reset) begin
      forward_a_e = FWD_RF;
      forward_b_e = FWD_RF;
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments on stall / flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_e && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver applies one decode-stage
// vector per cycle and queues the hand-computed outputs; the monitor
// pops and compares on the falling edge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic [1:0] id_result_src = '0;
  logic       ex_pc_src = 1'b0;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
  logic [31:0] exp_stall_cnt = '0;
  logic [31:0] exp_flush_cnt = '0;
`endif

  hazard_unit #(.REG_ADDR_W(5), .PERF_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_result_src (id_result_src),
    .ex_pc_src     (ex_pc_src),
    .forward_a_e   (forward_a_e),
    .forward_b_e   (forward_b_e),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .flush_e       (flush_e)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_cycles  (flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  // outs = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e}
  typedef struct {
    logic [7:0] outs;
    logic       rst;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we, input logic [1:0] src,
                      input logic pc, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic sd, input logic fd, input logic fe,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_reg_write  = we;
    id_result_src = src;
    ex_pc_src     = pc;
    e.outs = {fa, fb, sf, sd, fd, fe};
    e.rst  = rst;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic nop(input logic [1:0] fa, input logic [1:0] fb, input string name);
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, fa, fb, 1'b0, 1'b0, 1'b0, 1'b0, name);
  endtask

  // Monitor: compare each queued expectation against the live outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e};
      checks++;
      if (act !== e.outs) begin
        errors++;
        $display("FAIL %s: got fa/fb/sf/sd/fd/fe=%b expected %b", e.name, act, e.outs);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_cycles !== exp_stall_cnt || flush_cycles !== exp_flush_cnt) begin
        errors++;
        $display("FAIL %s_perf: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, stall_cycles, flush_cycles, exp_stall_cnt, exp_flush_cnt);
      end
      if (e.rst) begin
        exp_stall_cnt = '0;
        exp_flush_cnt = '0;
      end else begin
        exp_stall_cnt = exp_stall_cnt + {31'd0, e.outs[2]};
        exp_flush_cnt = exp_flush_cnt + {31'd0, e.outs[0]};
      end
`endif
    end
  end

  initial begin
    // Reset held with hazardous-looking decode inputs: outputs stay low.
    step(1, 5'd5, 5'd5, 5'd5, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0, "rst_hold_a");
    step(1, 5'd5, 5'd5, 5'd5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, "rst_hold_b");
    // add x5,x1,x2 ; add x6,x5,x3 back to back
    step(0, 5'd1, 5'd2, 5'd5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t1_producer");
    step(0, 5'd5, 5'd3, 5'd6, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t1_consumer_id");
    nop(2'b10, 2'b00, "t1_mem_fwd_a");
    // add x5 ; nop ; sub x7,x1,x5
    step(0, 5'd1, 5'd2, 5'd5, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t2_producer");
    nop(2'b00, 2'b00, "t2_nop");
    step(0, 5'd1, 5'd5, 5'd7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t2_consumer_id");
    nop(2'b00, 2'b01, "t2_wb_fwd_b");
    // add x8 ; add x8 ; add x9,x8,x8 -> MEM copy wins
    step(0, 5'd1, 5'd2, 5'd8, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t3_old_x8");
    step(0, 5'd3, 5'd4, 5'd8, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t3_new_x8");
    step(0, 5'd8, 5'd8, 5'd9, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t3_consumer_id");
    nop(2'b10, 2'b10, "t3_mem_priority");
    nop(2'b00, 2'b00, "t3_drain");
    // x0 writes/reads, including a load into x0 followed by an x0 reader
    step(0, 5'd1, 5'd2, 5'd0, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t4_write_x0");
    step(0, 5'd0, 5'd0, 5'd3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t4_read_x0_id");
    step(0, 5'd1, 5'd0, 5'd0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, "t4_x0_no_fwd");
    step(0, 5'd0, 5'd0, 5'd4, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t4_lw_x0_no_stall");
    nop(2'b00, 2'b00, "t4_drain");
    // lw x5 ; add x6,x5,x2 -> one bubble, then WB forward
    step(0, 5'd1, 5'd0, 5'd5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, "t5_load");
    step(0, 5'd5, 5'd2, 5'd6, 1, 2'b00, 0, 0, 0, 1, 1, 0, 1, "t5_load_use_stall");
    step(0, 5'd5, 5'd2, 5'd6, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t5_bubble_in_ex");
    nop(2'b01, 2'b00, "t5_wb_fwd_a");
    // lw x5 ; add x6,x5 with a taken branch in EX -> branch wins
    step(0, 5'd1, 5'd0, 5'd5, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, "t6_load");
    step(0, 5'd5, 5'd2, 5'd6, 1, 2'b00, 1, 0, 0, 0, 0, 1, 1, "t6_branch_wins");
    step(0, 5'd1, 5'd2, 5'd7, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "t6_target");
    // Build a stall+forward situation, then reset in the middle of it
    step(0, 5'd1, 5'd5, 5'd9, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "r_add_x9");
    step(0, 5'd9, 5'd0, 5'd10, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, "r_load_x10");
    step(1, 5'd10, 5'd9, 5'd11, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "r_reset_gates");
    step(0, 5'd10, 5'd9, 5'd11, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, "r_first_after_reset");
    nop(2'b00, 2'b00, "r_shadow_wiped");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
